pwm_multi_ch: RTL and testbench
===============================

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 Parameter N_CH, default 4, number of PWM channels sharing one timebase.
REQ-002 Parameter WIDTH, default 10, bit width of counter, period and duty values.
REQ-003 Parameter PRESCALE_W, default 16, bit width of the prescaler reload value.
REQ-004 MAX10_CLK1_50  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 EN  in  1  1 = timebase runs; 0 = counters hold, outputs hold last value.
REQ-007 PRESCALE  in  PRESCALE_W  one tick every PRESCALE+1 clocks; 0 = tick every clock.
REQ-008 PERIOD  in  WIDTH  edge mode: counter runs 0..PERIOD, i.e. PERIOD+1 ticks per PWM period.
REQ-009 DUTY  in  N_CH*WIDTH  packed per-channel duty; channel i = DUTY[i*WIDTH +: WIDTH].
REQ-010 LOAD  in  1  single-cycle request to capture PERIOD and DUTY into shadow registers.
REQ-011 PWM_OUT  out  N_CH  registered PWM outputs.
REQ-012 PERIOD_END  out  1  one-clock pulse on the tick that completes a PWM period.
REQ-013 LOAD_ACK  out  1  one-clock pulse when shadow values become active.

Function
REQ-014 The prescaler shall count down from PRESCALE to 0 while EN=1, assert an internal tick at 0, and reload PRESCALE on the same clock.
REQ-015 The main counter shall advance only on a tick; edge mode: increments, and on a tick at cnt==period_act wraps to 0.
REQ-016 PWM_OUT[i] shall be registered as (cnt < duty_act[i]), giving one clock of latency after the counter value.
REQ-017 duty_act[i]=0 shall hold PWM_OUT[i] low for the full period; duty_act[i] > period_act shall hold it high for the full period.
REQ-018 LOAD shall copy PERIOD and DUTY into shadow registers and set a pending flag; a later LOAD before the boundary overwrites the shadow (last write wins).
REQ-019 At the period boundary tick with pending set, active registers shall take shadow values, pending shall clear, and LOAD_ACK shall pulse on that same clock as PERIOD_END.
REQ-020 LOAD coincident with the boundary tick shall capture into the shadow and be applied at the next boundary, not the current one.
REQ-021 PERIOD_END shall pulse on every boundary tick, regardless of whether a load is pending.
REQ-022 PERIOD=0 shall be legal: every tick is a boundary; outputs follow REQ-017.
REQ-023 EN falling mid-period shall freeze prescaler, counter, outputs; EN rising shall resume from the frozen state with no skipped tick.

Reset
REQ-024 RST shall set prescaler to PRESCALE, cnt to 0, period_act and all duty_act to 0, shadows to 0, pending to 0.
REQ-025 During and on the clock after RST, PWM_OUT shall be all-zero, PERIOD_END=0, LOAD_ACK=0.
REQ-026 RST asserted mid-period shall take priority over EN, LOAD and tick on the same clock.

Configuration
REQ-027 Macro PWM_CENTER_ALIGN_EN, when defined, shall make the counter an up/down counter: 0 up to period_act, then down to 0; boundary = tick at cnt==0 while counting down; period = 2*PERIOD ticks (PERIOD=0: every tick is a boundary).
REQ-028 With PWM_CENTER_ALIGN_EN defined, the compare rule of REQ-016 shall be unchanged, producing centre-aligned pulses; without it, only edge-aligned sawtooth counting shall be compiled.

Structure
REQ-029 Package pwm_pkg shall hold default values of N_CH, WIDTH, PRESCALE_W and the direction enum {DIR_UP, DIR_DOWN} used in centre mode.
REQ-030 The prescaler shall be a separate sub-module pwm_prescaler (inputs clock, RST, EN, PRESCALE; output tick); everything else lives in pwm_multi_ch.

Verification
REQ-031 RST=1 then release, EN=1, PRESCALE=0, no LOAD -> PWM_OUT=0 continuously, PERIOD_END pulses every clock (PERIOD_act=0).
REQ-032 PRESCALE=0, LOAD with PERIOD=9, DUTY={0,3,5,15} -> after LOAD_ACK: ch0 always low, ch1 high 3 of 10 clocks, ch2 high 5 of 10, ch3 always high; PERIOD_END every 10 clocks.
REQ-033 PRESCALE=4, PERIOD=999, DUTY ch0=500 -> PERIOD_END every 5000 clocks, ch0 high 2500 clocks per period.
REQ-034 Mid-period LOAD of DUTY ch1=7 -> old duty persists until boundary; LOAD_ACK and PERIOD_END coincide; new duty in the next period only; LOAD on boundary tick applied one period later.
REQ-035 EN dropped for 17 clocks at cnt=4 -> counter and outputs frozen; period lengthened by exactly 17 clocks.
REQ-036 With PWM_CENTER_ALIGN_EN, PERIOD=4, DUTY ch0=2, PRESCALE=0 -> count 0,1,2,3,4,3,2,1 repeating, ch0 high on cnt 0,1 (centred at wrap), PERIOD_END every 8 clocks.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the multi-channel PWM block.
// The direction enum is only referenced when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;
  localparam int N_CH_DEF       = 4;
  localparam int WIDTH_DEF      = 10;
  localparam int PRESCALE_W_DEF = 16;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;
endpackage

// File: rtl/pwm_prescaler.sv
// Timebase prescaler: down-counter that emits one tick every prescale+1 clocks.
// The tick is decoded from the count register; the count freezes while en is low.
module pwm_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= prescale;
    end else if (en) begin
      pcnt <= (pcnt == '0) ? prescale : pcnt - ONE;
    end
  end
endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM on a shared timebase with shadowed period/duty applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN for up/down (centre-aligned) counting; default is edge-aligned sawtooth.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [WIDTH-1:0]      PERIOD,
  input  logic [N_CH*WIDTH-1:0] DUTY,
  input  logic                  LOAD,
  output logic [N_CH-1:0]       PWM_OUT,
  output logic                  PERIOD_END,
  output logic                  LOAD_ACK
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic                  tick;
  logic                  boundary;
  logic                  apply;
  logic [WIDTH-1:0]      cnt;
  logic [WIDTH-1:0]      period_act;
  logic [WIDTH-1:0]      period_shd;
  logic [N_CH*WIDTH-1:0] duty_act;
  logic [N_CH*WIDTH-1:0] duty_shd;
  logic                  pending;
  logic [N_CH-1:0]       cmp;
`ifdef PWM_CENTER_ALIGN_EN
  logic [WIDTH-1:0]      period_nxt;
  dir_t                  dir;
`endif

  pwm_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (MAX10_CLK1_50),
    .rst      (RST),
    .en       (EN),
    .prescale (PRESCALE),
    .tick     (tick)
  );

  always_comb begin
    cmp = '0;
`ifdef PWM_CENTER_ALIGN_EN
    // A zero period would never reach the down-count zero, so every tick closes a period.
    boundary   = tick && (((dir == DIR_DOWN) && (cnt == '0)) || (period_act == '0));
    apply      = boundary && pending;
    period_nxt = apply ? period_shd : period_act;
`else
    boundary   = tick && (cnt == period_act);
    apply      = boundary && pending;
`endif
    for (int i = 0; i < N_CH; i++) begin
      cmp[i] = cnt < duty_act[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      cnt        <= '0;
      period_act <= '0;
      duty_act   <= '0;
      period_shd <= '0;
      duty_shd   <= '0;
      pending    <= 1'b0;
      PWM_OUT    <= '0;
      PERIOD_END <= 1'b0;
      LOAD_ACK   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir        <= DIR_UP;
`endif
    end else begin
      PERIOD_END <= boundary;
      LOAD_ACK   <= apply;
      if (EN) begin
        PWM_OUT <= cmp;
      end

      // A LOAD on the boundary tick refills the shadow and stays pending for the next boundary.
      if (LOAD) begin
        period_shd <= PERIOD;
        duty_shd   <= DUTY;
        pending    <= 1'b1;
      end else if (boundary) begin
        pending    <= 1'b0;
      end

      if (apply) begin
        period_act <= period_shd;
        duty_act   <= duty_shd;
      end

      if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
        if (boundary) begin
          if (period_nxt == '0) begin
            cnt <= '0;
            dir <= DIR_DOWN;
          end else begin
            cnt <= ONE;
            dir <= DIR_UP;
          end
        end else if ((dir == DIR_UP) && (cnt < period_act)) begin
          cnt <= cnt + ONE;
        end else begin
          cnt <= cnt - ONE;
          dir <= DIR_DOWN;
        end
`else
        cnt <= boundary ? '0 : cnt + ONE;
`endif
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: per-period length and per-channel high-time measurement.
module tb_pwm_multi_ch;
  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] prescale;
  logic [9:0]  period;
  logic [39:0] duty;
  logic        load;
  logic [3:0]  pwm_out;
  logic        period_end;
  logic        load_ack;

  int tests;
  int fails;
  int exp_q[$];
  int m_len;
  int m_hi[4];
  bit m_ack;

  typedef struct {
    logic [15:0] pre;
    logic [9:0]  per;
    logic [39:0] dut;
    int          len;
    int          h0;
    int          h1;
    int          h2;
    int          h3;
  } vec_t;

  vec_t vecs[5];

  pwm_multi_ch dut (
    .MAX10_CLK1_50 (clk),
    .RST           (rst),
    .EN            (en),
    .PRESCALE      (prescale),
    .PERIOD        (period),
    .DUTY          (duty),
    .LOAD          (load),
    .PWM_OUT       (pwm_out),
    .PERIOD_END    (period_end),
    .LOAD_ACK      (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input int act);
    int e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got %0d, expected value missing from scoreboard", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act != e) begin
        fails++;
        $display("FAIL %s: got %0d, expected %0d", nm, act, e);
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] pre, input logic [9:0] per, input logic [39:0] d);
    prescale = pre;
    period   = per;
    duty     = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (load_ack) begin
        ok = 1;
        break;
      end
    end
    check({nm, "_ack_seen"}, int'(ok), 1);
    check({nm, "_ack_with_pe"}, int'(period_end), 1);
  endtask

  // Starts on a cycle where PERIOD_END is high and samples until the next one.
  task automatic run_period(input int load_at, input logic [9:0] nper, input logic [39:0] nduty,
                            input int en_at, input int en_len);
    int len;
    bit to;
    len = 0;
    to  = 0;
    for (int c = 0; c < 4; c++) m_hi[c] = 0;
    forever begin
      if (en_at >= 0 && len == en_at) en = 1'b0;
      if (en_at >= 0 && len == en_at + en_len) en = 1'b1;
      if (len == load_at) begin
        period = nper;
        duty   = nduty;
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      for (int c = 0; c < 4; c++) m_hi[c] += int'(pwm_out[c]);
      len++;
      @(negedge clk);
      if (period_end) break;
      if (len >= 20000) begin
        to = 1;
        break;
      end
    end
    load  = 1'b0;
    en    = 1'b1;
    m_len = len;
    m_ack = load_ack;
    check("period_timeout", int'(to), 0);
  endtask

  initial begin
    int pe_cnt;
    int ack_cnt;
    int pwm_hi;

    tests = 0;
    fails = 0;
    vecs[0] = '{16'd0, 10'd9,   {10'd15,  10'd5,    10'd3, 10'd0},   10,   0,    3,    5,    10};
    vecs[1] = '{16'd4, 10'd999, {10'd999, 10'd1000, 10'd0, 10'd500}, 5000, 2500, 0,    5000, 4995};
    vecs[2] = '{16'd0, 10'd0,   {10'd0,   10'd2,    10'd1, 10'd0},   1,    0,    1,    1,    0};
    vecs[3] = '{16'd2, 10'd5,   {10'd0,   10'd6,    10'd1, 10'd4},   18,   12,   3,    18,   0};
    vecs[4] = '{16'd1, 10'd3,   {10'd1,   10'd4,    10'd2, 10'd3},   8,    6,    4,    8,    2};

    rst      = 1'b1;
    en       = 1'b1;
    prescale = 16'd0;
    period   = 10'd0;
    duty     = 40'd0;
    load     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_period_end", int'(period_end), 0);
    check("rst_load_ack", int'(load_ack), 0);
    rst = 1'b0;

    // Zero active period after reset: every clock closes a period, outputs stay low.
    pe_cnt = 0; ack_cnt = 0; pwm_hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pe_cnt  += int'(period_end);
      ack_cnt += int'(load_ack);
      pwm_hi  += int'(pwm_out != 4'd0);
    end
    check("post_rst_pe_every_clk", pe_cnt, 8);
    check("post_rst_no_ack", ack_cnt, 0);
    check("post_rst_pwm_low", pwm_hi, 0);

`ifdef PWM_CENTER_ALIGN_EN
    pulse_load(16'd0, 10'd4, {10'd0, 10'd5, 10'd4, 10'd2});
    wait_ack("ctr");
    run_period(-1, 10'd4, {10'd0, 10'd5, 10'd4, 10'd2}, -1, 0);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8); exp_q.push_back(3); exp_q.push_back(7);
      exp_q.push_back(8); exp_q.push_back(0);
      run_period(-1, 10'd4, {10'd0, 10'd5, 10'd4, 10'd2}, -1, 0);
      chk_q($sformatf("ctr%0d_len", r), m_len);
      for (int c = 0; c < 4; c++) chk_q($sformatf("ctr%0d_hi%0d", r, c), m_hi[c]);
    end
`else
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].len);
      exp_q.push_back(vecs[i].h0);
      exp_q.push_back(vecs[i].h1);
      exp_q.push_back(vecs[i].h2);
      exp_q.push_back(vecs[i].h3);
      pulse_load(vecs[i].pre, vecs[i].per, vecs[i].dut);
      wait_ack($sformatf("v%0d", i));
      run_period(-1, vecs[i].per, vecs[i].dut, -1, 0);
      run_period(-1, vecs[i].per, vecs[i].dut, -1, 0);
      chk_q($sformatf("v%0d_len", i), m_len);
      for (int c = 0; c < 4; c++) chk_q($sformatf("v%0d_hi%0d", i, c), m_hi[c]);
    end

    pulse_load(16'd0, 10'd9, {10'd15, 10'd5, 10'd3, 10'd0});
    wait_ack("seq");
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd3, 10'd0}, -1, 0);

    // Mid-period LOAD: old duty holds for the rest of this period, ack lands on the boundary.
    exp_q.push_back(10); exp_q.push_back(3); exp_q.push_back(1);
    run_period(3, 10'd9, {10'd15, 10'd5, 10'd7, 10'd0}, -1, 0);
    chk_q("mid_len", m_len); chk_q("mid_hi1_old", m_hi[1]); chk_q("mid_ack", int'(m_ack));

    exp_q.push_back(10); exp_q.push_back(7); exp_q.push_back(0);
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd7, 10'd0}, -1, 0);
    chk_q("new_len", m_len); chk_q("new_hi1", m_hi[1]); chk_q("new_ack", int'(m_ack));

    // LOAD on the boundary tick itself is deferred by one full period.
    exp_q.push_back(7); exp_q.push_back(0);
    run_period(9, 10'd9, {10'd15, 10'd5, 10'd2, 10'd0}, -1, 0);
    chk_q("bnd_hi1", m_hi[1]); chk_q("bnd_no_ack", int'(m_ack));

    exp_q.push_back(7); exp_q.push_back(1);
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd2, 10'd0}, -1, 0);
    chk_q("bnd_next_hi1", m_hi[1]); chk_q("bnd_next_ack", int'(m_ack));

    exp_q.push_back(10); exp_q.push_back(2);
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd2, 10'd0}, -1, 0);
    chk_q("bnd_applied_len", m_len); chk_q("bnd_applied_hi1", m_hi[1]);

    // EN low for 17 clocks at cnt=4 stretches the period and the frozen output level.
    exp_q.push_back(27); exp_q.push_back(2); exp_q.push_back(22); exp_q.push_back(27);
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd2, 10'd0}, 4, 17);
    chk_q("en_len", m_len); chk_q("en_hi1", m_hi[1]);
    chk_q("en_hi2", m_hi[2]); chk_q("en_hi3", m_hi[3]);

    exp_q.push_back(10);
    run_period(-1, 10'd9, {10'd15, 10'd5, 10'd2, 10'd0}, -1, 0);
    chk_q("en_resume_len", m_len);
`endif

    // Mid-period reset wins over a coincident LOAD and clears the active settings.
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    load   = 1'b1;
    period = 10'd9;
    duty   = {4{10'd15}};
    @(negedge clk);
    check("rstp_pwm", int'(pwm_out), 0);
    check("rstp_period_end", int'(period_end), 0);
    check("rstp_load_ack", int'(load_ack), 0);
    rst  = 1'b0;
    load = 1'b0;
    pe_cnt = 0; ack_cnt = 0; pwm_hi = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pe_cnt  += int'(period_end);
      ack_cnt += int'(load_ack);
      pwm_hi  += int'(pwm_out != 4'd0);
    end
    check("rstp_pe_every_clk", pe_cnt, 5);
    check("rstp_load_dropped", ack_cnt, 0);
    check("rstp_pwm_low", pwm_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
